seq_det_scan_ctrl: RTL and testbench

//  Sequencer for the serial 1001 sequence detector (SeqDet).
//  - Accepts a parallel word over a valid/ready handshake.
//  - Shifts the word MSB-first into the detector, one bit per clk.
//  - Optionally clears detector history before the word.
//  - Collects detector hits and returns a summary record: hit count, first-hit index, hit flag.

---
 rtl/seq_det_ctrl_pkg.sv | 14 +
 rtl/seq_det_hit_tap.sv | 36 +++
 rtl/seq_det_scan_ctrl.sv | 118 +++++++++++
 tb/tb_seq_det_scan_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_ctrl_pkg.sv
// Shared types and defaults for the 1001 sequence-detector scan controller.
package seq_det_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLR   = 3'd1,
      SHIFT = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int SEQ_DET_LAT_DEFAULT = 1;

endpackage

// File: rtl/seq_det_hit_tap.sv
// Delay line that aligns each shifted bit's {valid, index} tag with the
// detector response that bit produces LAT clocks later.
module seq_det_hit_tap #(
   parameter int LAT   = 1,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             launch,
   input  logic [CNT_W-1:0] launch_idx,
   output logic             tap_valid,
   output logic [CNT_W-1:0] tap_idx
);

   logic [LAT-1:0]   vld_pipe;
   logic [CNT_W-1:0] idx_pipe [LAT];

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
      end else begin
         for (int i = LAT - 1; i > 0; i--) vld_pipe[i] <= vld_pipe[i-1];
         vld_pipe[0] <= launch;
      end
   end

   // Index slots need no reset: they are only read alongside a valid bit.
   always_ff @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) idx_pipe[i] <= idx_pipe[i-1];
      idx_pipe[0] <= launch_idx;
   end

   assign tap_valid = vld_pipe[LAT-1];
   assign tap_idx   = idx_pipe[LAT-1];

endmodule

// File: rtl/seq_det_scan_ctrl.sv
// Scan controller: accepts a word, shifts it MSB-first into the 1001 detector,
// and returns hit count / first-hit index once the detector pipeline drains.
module seq_det_scan_ctrl
   import seq_det_ctrl_pkg::*;
#(
   parameter  int DATA_W = 16,
   parameter  int LAT    = SEQ_DET_LAT_DEFAULT,
   localparam int CNT_W  = $clog2(DATA_W + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inValid,
   output logic              inReady,
   input  logic [DATA_W-1:0] inData,
   input  logic              inClr,
   output logic              seqOut,
   output logic              seqEn,
   output logic              detClr,
   input  logic              detIn,
   output logic              outValid,
   input  logic              outReady,
   output logic [CNT_W-1:0]  outCount,
   output logic [CNT_W-1:0]  outFirst,
   output logic              outHit,
   output logic [2:0]        dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; valid and its payload stay stable until that edge.

   localparam int DR_W = (LAT < 2) ? 1 : $clog2(LAT + 1);

   state_t            state;
   state_t            next_state;
   logic [DATA_W-1:0] shreg;
   logic [CNT_W-1:0]  bit_idx;
   logic [DR_W-1:0]   drain_cnt;
   logic [CNT_W-1:0]  out_count;
   logic [CNT_W-1:0]  out_first;
   logic              tap_valid;
   logic [CNT_W-1:0]  tap_idx;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (inValid) next_state = inClr ? CLR : SHIFT;
         CLR:     next_state = SHIFT;
         SHIFT:   if (bit_idx == CNT_W'(DATA_W - 1)) next_state = DRAIN;
         DRAIN:   if (drain_cnt == DR_W'(LAT - 1)) next_state = DONE;
         DONE:    if (outReady) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      inReady   = (state == IDLE) && !rst;
      seqEn     = (state == SHIFT);
      seqOut    = (state == SHIFT) && shreg[DATA_W-1];
      detClr    = (state == CLR);
      outValid  = (state == DONE);
      outCount  = out_count;
      outFirst  = out_first;
      outHit    = (out_count != '0);
      dbg_state = state;
   end

   seq_det_hit_tap #(
      .LAT   (LAT),
      .CNT_W (CNT_W)
   ) u_hit_tap (
      .clk        (clk),
      .rst        (rst),
      .launch     (seqEn),
      .launch_idx (bit_idx),
      .tap_valid  (tap_valid),
      .tap_idx    (tap_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg     <= '0;
         bit_idx   <= '0;
         drain_cnt <= '0;
         out_count <= '0;
         out_first <= '0;
      end else begin
         // Tags are empty by the time DONE/IDLE is reached, so the accept-time
         // clear below never collides with a hit update.
         if (tap_valid && detIn) begin
            out_count <= out_count + 1'b1;
            if (out_count == '0) out_first <= tap_idx;
         end
         case (state)
            IDLE: begin
               if (inValid) begin
                  shreg     <= inData;
                  bit_idx   <= '0;
                  drain_cnt <= '0;
                  out_count <= '0;
                  out_first <= '0;
               end
            end
            SHIFT: begin
               shreg   <= {shreg[DATA_W-2:0], 1'b0};
               bit_idx <= bit_idx + 1'b1;
            end
            DRAIN:   drain_cnt <= drain_cnt + 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_det_scan_ctrl.sv
// Bench for seq_det_scan_ctrl with a behavioural 1001 detector (latency 1).
module tb_seq_det_scan_ctrl;

   localparam int DATA_W = 16;
   localparam int LAT    = 1;
   localparam int CNT_W  = 5;
   localparam int EXP_W  = 19;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              inValid = 1'b0;
   logic              inReady;
   logic [DATA_W-1:0] inData = '0;
   logic              inClr = 1'b0;
   logic              seqOut;
   logic              seqEn;
   logic              detClr;
   logic              detIn;
   logic              outValid;
   logic              outReady = 1'b1;
   logic [CNT_W-1:0]  outCount;
   logic [CNT_W-1:0]  outFirst;
   logic              outHit;
   logic [2:0]        dbg_state;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int accept_cyc = 0;

   // entry = {latency[7:0], hit, first[4:0], count[4:0]}
   logic [EXP_W-1:0] exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seq_det_scan_ctrl #(.DATA_W(DATA_W), .LAT(LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .inValid   (inValid),
      .inReady   (inReady),
      .inData    (inData),
      .inClr     (inClr),
      .seqOut    (seqOut),
      .seqEn     (seqEn),
      .detClr    (detClr),
      .detIn     (detIn),
      .outValid  (outValid),
      .outReady  (outReady),
      .outCount  (outCount),
      .outFirst  (outFirst),
      .outHit    (outHit),
      .dbg_state (dbg_state)
   );

   // Detector model: registered 1001 match, history kept until detClr.
   logic [3:0] det_hist = '0;
   logic       det_out = 1'b0;
   logic       noise = 1'b0;
   always @(posedge clk) begin
      if (detClr) begin
         det_hist <= '0;
         det_out  <= 1'b0;
      end else if (seqEn) begin
         det_hist <= {det_hist[2:0], seqOut};
         det_out  <= ({det_hist[2:0], seqOut} == 4'b1001);
      end
   end
   assign detIn = det_out | noise;

   task automatic check(input string nm, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Monitor: pop and compare on every output handshake.
   always @(negedge clk) begin
      logic [EXP_W-1:0] e;
      if (outValid && outReady) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out count=%0d first=%0d hit=%0d", outCount, outFirst, outHit);
         end else begin
            e = exp_q.pop_front();
            check("out_count", int'(outCount), int'(e[4:0]));
            check("out_first", int'(outFirst), int'(e[9:5]));
            check("out_hit", int'(outHit), int'(e[10]));
            check("out_latency", cyc - accept_cyc + 1, int'(e[18:11]));
         end
      end
   end

   task automatic send(input logic [DATA_W-1:0] d, input logic c, input bit push,
                       input int ec, input int ef, input int elat);
      int n;
      n = 0;
      inData  = d;
      inClr   = c;
      inValid = 1'b1;
      while (!inReady && n < 200) begin
         tick();
         n++;
      end
      if (!inReady) begin
         check("accept_timeout", 0, 1);
         inValid = 1'b0;
         return;
      end
      if (push) exp_q.push_back({8'(elat), (ec != 0), 5'(ef), 5'(ec)});
      tick();
      inValid    = 1'b0;
      accept_cyc = cyc;
      check("det_clr_cycle1", int'(detClr), int'(c));
      check("seq_en_cycle1", int'(seqEn), int'(!c));
      if (c) begin
         tick();
         check("det_clr_single_pulse", int'(detClr), 0);
         check("seq_en_cycle2", int'(seqEn), 1);
      end
   endtask

   task automatic wait_idle;
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      check("results_drained", exp_q.size(), 0);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout cycle=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      check("rst_in_ready", int'(inReady), 0);
      check("rst_seq_en", int'(seqEn), 0);
      check("rst_seq_out", int'(seqOut), 0);
      check("rst_det_clr", int'(detClr), 0);
      check("rst_out_valid", int'(outValid), 0);
      check("rst_out_count", int'(outCount), 0);
      check("rst_out_first", int'(outFirst), 0);
      check("rst_out_hit", int'(outHit), 0);
      rst = 1'b0;
      tick();
      check("idle_in_ready", int'(inReady), 1);

      send(16'h9000, 1'b1, 1'b1, 1, 3, 19);
      send(16'h9200, 1'b1, 1'b1, 2, 3, 19);
      send(16'h0000, 1'b0, 1'b1, 0, 0, 18);
      // A pattern spanning two words is seen when history is kept.
      send(16'h0004, 1'b0, 1'b1, 0, 0, 18);
      send(16'h8000, 1'b0, 1'b1, 1, 0, 18);
      send(16'h0004, 1'b0, 1'b1, 0, 0, 18);
      send(16'h8000, 1'b1, 1'b1, 0, 0, 19);
      // Hit completing on the last bit is only seen during the drain.
      send(16'h0009, 1'b1, 1'b1, 1, 15, 19);
      wait_idle();

      // Consumer stalls for 5 clocks in DONE.
      outReady = 1'b0;
      send(16'h9249, 1'b1, 1'b1, 5, 3, 24);
      for (int n = 0; n < 200 && !outValid; n++) tick();
      for (int i = 0; i < 5; i++) begin
         check("stall_out_valid", int'(outValid), 1);
         check("stall_out_count", int'(outCount), 5);
         check("stall_out_first", int'(outFirst), 3);
         check("stall_out_hit", int'(outHit), 1);
         check("stall_in_ready", int'(inReady), 0);
         check("stall_seq_en", int'(seqEn), 0);
         tick();
      end
      outReady = 1'b1;
      tick();
      check("release_in_ready", int'(inReady), 1);
      wait_idle();

      // detIn activity outside tagged cycles must not count.
      noise = 1'b1;
      repeat (3) tick();
      send(16'h0000, 1'b1, 1'b1, 0, 0, 19);
      noise = 1'b0;
      wait_idle();

      // Reset in the middle of SHIFT drops the word.
      send(16'hFFFF, 1'b0, 1'b0, 0, 0, 0);
      repeat (6) tick();
      check("mid_shift_seq_en", int'(seqEn), 1);
      rst = 1'b1;
      tick();
      check("mid_rst_in_ready", int'(inReady), 0);
      check("mid_rst_seq_en", int'(seqEn), 0);
      rst = 1'b0;
      tick();
      check("post_rst_in_ready", int'(inReady), 1);
      check("post_rst_seq_en", int'(seqEn), 0);
      for (int i = 0; i < 25; i++) begin
         check("post_rst_no_out", int'(outValid), 0);
         tick();
      end
      send(16'h9000, 1'b0, 1'b1, 1, 3, 18);
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
